pwm_frame_controller: RTL
=========================

// Module: pwm_frame_controller
// PURPOSE
//  Sequences the four pwm_generator_block instances. Owns the shared PWM timebase (period_counter, high_counter).
//  Accepts throttle updates from the flight controller and commits them only on frame boundaries.
//  Runs the disarmed -> arming -> run -> failsafe sequence, forcing zero throttle whenever the motors must not spin.
//  Sits between the flight/attitude logic and the pwm_generator_block bank.
// PARAMETERS
//  INPUT_BIT_WIDTH  10  width of each motor value and of high_counter
//  ARM_FRAMES       50  number of zero-throttle frames emitted in ARMING before RUN
//  TIMEOUT_FRAMES   10  consecutive frames with no accepted update before entering FAILSAFE
// PORTS
//  us_clk          in   1      1 MHz clock
//  resetn          in   1      asynchronous, active-low reset
//  arm_req         in   1      level: 1 = request armed, 0 = disarm
//  upd_valid       in   1      throttle update valid
//  upd_ready       out  1      controller can accept an update
//  upd_motor       in   4*W    {m3,m2,m1,m0}, W = INPUT_BIT_WIDTH
//  motor_val_0..3  out  W      committed throttle per generator
//  period_counter  out  16     shared frame timebase
//  high_counter    out  W      us elapsed beyond the minimum high time
//  frame_start     out  1      one-cycle pulse in the cycle period_counter == 0
//  armed           out  1      state is RUN or FAILSAFE
//  failsafe        out  1      state is FAILSAFE
// BEHAVIOUR
//  Constants: MIN_PWM_TIME_HIGH_US = 1000, MAX_PWM_TIME_HIGH_US = 2000, PWM_PERIOD_US = 2500.
//  Reset values: state DISARMED, period_counter 0, high_counter 0, all motor_val 0, frame_start 0,
//   armed 0, failsafe 0, shadow empty, upd_ready 1.
//  Timebase: period_counter counts 0..PWM_PERIOD_US, then wraps to 0 (frame = PERIOD+1 cycles).
//   high_counter = 0 while period_counter <= MIN; otherwise period_counter - MIN, saturating at 2^W-1.
//   The timebase free-runs in every state.
//  Boundary: the cycle with period_counter == PWM_PERIOD_US. All commits and state changes are registered
//   here and become visible when period_counter == 0.
//  Handshake: a transfer occurs when upd_valid && upd_ready.
//   Data goes to a one-entry shadow register. upd_ready = !shadow_full.
//   Each lane is clamped to MAX - MIN = 1000 on capture (e.g. 1023 -> 1000).
//  Commit at boundary:
//   - shadow_full: active <= shadow; shadow cleared.
//   - shadow empty and a transfer occurs in the boundary cycle: active <= clamped upd_motor directly.
//   - otherwise active holds.
//  Transfers in non-boundary cycles with the shadow full are impossible (ready = 0).
//  A second update before the boundary waits; it is never overwritten or dropped.
//  Outputs: motor_val_x = active_x in RUN; 0 in DISARMED, ARMING and FAILSAFE.
//  Staleness: stale_cnt resets to 0 on every boundary that commits data. Otherwise it increments, saturating at TIMEOUT_FRAMES.
//  FSM (transitions evaluated only at boundary, except disarm):
//   DISARMED: arm_req -> ARMING, frame_cnt = 0.
//   ARMING: count frames; after ARM_FRAMES boundaries -> RUN, stale_cnt = 0. Updates are accepted but forced to 0 at the output.
//   RUN: stale_cnt reaches TIMEOUT_FRAMES -> FAILSAFE.
//   FAILSAFE: a boundary that commits data -> RUN.
//  Disarm: arm_req = 0 in any state -> DISARMED on the next clock, not waiting for a boundary.
//   motor_val forced to 0 that same edge. Shadow and active cleared.
//  Reset mid-frame: all of the above return to their reset values immediately.
//   The first frame after reset is a full frame starting at 0.
//  Simultaneous events at one boundary: disarm beats arming/commit.
//   A commit beats a timeout, so RUN stays RUN.
// STRUCTURE
//  Shared package common_defines: MIN/MAX_PWM_TIME_HIGH_US, PWM_PERIOD_US, FSM state encodings.
//  Sub-module pwm_timebase: period_counter, high_counter, frame_start, boundary strobe.
//  Top level holds the FSM, shadow/active registers, clamps and counters.
// TESTING
//  1. Reset, arm_req = 0 for 3 frames -> motor_val all 0, armed = 0, upd accepted but no output change.
//  2. arm_req = 1, ARM_FRAMES = 50 -> armed rises at period_counter == 0 after the 50th boundary.
//     Output 0 throughout ARMING.
//  3. In RUN, send m0 = 300 at period_counter = 100, then m0 = 600 at 200.
//     -> upd_ready = 0 after the first transfer; 300 appears at the next frame start.
//     -> 600 is accepted after that boundary and appears one frame later.
//  4. Send lane value 1023 -> committed value 1000.
//     Check high_counter = period_counter - 1000 beyond 1000 and 0 at or below.
//  5. No updates for 10 frames in RUN -> failsafe = 1, outputs 0.
//     Update 500 -> RUN at the next boundary, motor_val = 500.
//  6. Drop arm_req at period_counter = 1500 in RUN -> motor_val = 0 the next cycle, state DISARMED.
//     Assert resetn low mid-frame -> period_counter 0, all outputs at reset values.

Source files
------------

// File: rtl/pwm_frame_controller_pkg.sv
// Shared timing constants and FSM encoding for the PWM frame controller slice.
package pwm_frame_controller_pkg;

  localparam int unsigned MIN_PWM_TIME_HIGH_US = 1000;
  localparam int unsigned MAX_PWM_TIME_HIGH_US = 2000;
  localparam int unsigned PWM_PERIOD_US        = 2500;

  typedef enum logic [1:0] {
    StDisarmed = 2'd0,
    StArming   = 2'd1,
    StRun      = 2'd2,
    StFailsafe = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pwm_frame_controller_if.sv
// Throttle update handshake between the flight controller and the frame controller.
interface pwm_frame_controller_if #(
  parameter int unsigned Width = 10
) ();

  logic               upd_valid;
  logic               upd_ready;
  logic [4*Width-1:0] upd_motor;

  modport master (
    output upd_valid,
    output upd_motor,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_motor,
    output upd_ready
  );

endinterface

// File: rtl/pwm_frame_controller_timebase.sv
// Free-running shared PWM frame timebase: period/high counters, frame start and boundary strobe.
module pwm_frame_controller_timebase
  import pwm_frame_controller_pkg::*;
#(
  parameter int unsigned INPUT_BIT_WIDTH = 10
) (
  input  logic                       us_clk,
  input  logic                       resetn,
  output logic [15:0]                period_counter,
  output logic [INPUT_BIT_WIDTH-1:0] high_counter,
  output logic                       frame_start,
  output logic                       boundary
);

  localparam logic [15:0] PeriodLast = 16'(PWM_PERIOD_US);
  localparam logic [15:0] MinHigh    = 16'(MIN_PWM_TIME_HIGH_US);
  localparam logic [15:0] HighSat    = 16'((32'd1 << INPUT_BIT_WIDTH) - 32'd1);

  logic [15:0] excess;

  assign boundary = (period_counter == PeriodLast);
  assign excess   = period_counter - MinHigh;

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      period_counter <= '0;
      frame_start    <= 1'b0;
    end else begin
      period_counter <= boundary ? 16'd0 : period_counter + 16'd1;
      // Registered so it lines up with period_counter == 0 but stays low out of reset.
      frame_start    <= boundary;
    end
  end

  always_comb begin
    high_counter = '0;
    if (period_counter <= MinHigh) begin
      high_counter = '0;
    end else if (excess > HighSat) begin
      high_counter = '1;
    end else begin
      high_counter = excess[INPUT_BIT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pwm_frame_controller.sv
// Frame controller: arming FSM, frame-aligned throttle commit and failsafe for four PWM generators.
module pwm_frame_controller
  import pwm_frame_controller_pkg::*;
#(
  parameter int unsigned INPUT_BIT_WIDTH = 10,
  parameter int unsigned ARM_FRAMES      = 50,
  parameter int unsigned TIMEOUT_FRAMES  = 10
) (
  input  logic                       us_clk,
  input  logic                       resetn,
  input  logic                       arm_req,
  pwm_frame_controller_if.slave      upd,
  output logic [INPUT_BIT_WIDTH-1:0] motor_val_0,
  output logic [INPUT_BIT_WIDTH-1:0] motor_val_1,
  output logic [INPUT_BIT_WIDTH-1:0] motor_val_2,
  output logic [INPUT_BIT_WIDTH-1:0] motor_val_3,
  output logic [15:0]                period_counter,
  output logic [INPUT_BIT_WIDTH-1:0] high_counter,
  output logic                       frame_start,
  output logic                       armed,
  output logic                       failsafe
);

  localparam int unsigned W         = INPUT_BIT_WIDTH;
  localparam int unsigned LanesW    = 4 * W;
  localparam int unsigned FrameCntW = $clog2(ARM_FRAMES + 1);
  localparam int unsigned StaleW    = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [W-1:0]         LaneMax  = W'(MAX_PWM_TIME_HIGH_US - MIN_PWM_TIME_HIGH_US);
  localparam logic [FrameCntW-1:0] ArmLast  = FrameCntW'(ARM_FRAMES - 1);
  localparam logic [StaleW-1:0]    StaleMax = StaleW'(TIMEOUT_FRAMES);

  function automatic logic [LanesW-1:0] clamp_lanes(logic [LanesW-1:0] raw);
    logic [LanesW-1:0] res;
    logic [W-1:0]      lane;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      lane           = raw[i*W +: W];
      res[i*W +: W]  = (lane > LaneMax) ? LaneMax : lane;
    end
    return res;
  endfunction

  ctrl_state_e          state_q, state_d;
  logic [LanesW-1:0]    shadow_q, shadow_d;
  logic                 shadow_full_q, shadow_full_d;
  logic [LanesW-1:0]    active_q, active_d;
  logic [FrameCntW-1:0] frame_cnt_q, frame_cnt_d;
  logic [StaleW-1:0]    stale_q, stale_d, stale_next;
  logic [LanesW-1:0]    motor_q;
  logic                 armed_q, failsafe_q;

  logic              boundary;
  logic              transfer;
  logic              commit;
  logic [LanesW-1:0] clamped;
  logic [LanesW-1:0] commit_data;

  pwm_frame_controller_timebase #(
    .INPUT_BIT_WIDTH (INPUT_BIT_WIDTH)
  ) u_timebase (
    .us_clk         (us_clk),
    .resetn         (resetn),
    .period_counter (period_counter),
    .high_counter   (high_counter),
    .frame_start    (frame_start),
    .boundary       (boundary)
  );

  assign upd.upd_ready = !shadow_full_q;
  assign transfer      = upd.upd_valid && !shadow_full_q;
  assign clamped       = clamp_lanes(upd.upd_motor);
  // A full shadow blocks transfers, so the boundary commit takes either the shadow or the bus.
  assign commit        = boundary && (shadow_full_q || transfer);
  assign commit_data   = shadow_full_q ? shadow_q : clamped;
  assign stale_next    = commit ? '0 :
                         (stale_q == StaleMax) ? stale_q : stale_q + StaleW'(1);

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    frame_cnt_d   = frame_cnt_q;
    stale_d       = stale_q;
    if (!arm_req) begin
      state_d       = StDisarmed;
      shadow_d      = '0;
      shadow_full_d = 1'b0;
      active_d      = '0;
      frame_cnt_d   = '0;
      stale_d       = '0;
    end else if (boundary) begin
      if (commit) begin
        active_d      = commit_data;
        shadow_full_d = 1'b0;
      end
      stale_d = stale_next;
      unique case (state_q)
        StDisarmed: begin
          state_d     = StArming;
          frame_cnt_d = '0;
        end
        StArming: begin
          if (frame_cnt_q == ArmLast) begin
            state_d = StRun;
            stale_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + FrameCntW'(1);
          end
        end
        StRun: begin
          if (stale_next == StaleMax) state_d = StFailsafe;
        end
        StFailsafe: begin
          if (commit) state_d = StRun;
        end
      endcase
    end else if (transfer) begin
      shadow_d      = clamped;
      shadow_full_d = 1'b1;
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StDisarmed;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= '0;
      frame_cnt_q   <= '0;
      stale_q       <= '0;
      motor_q       <= '0;
      armed_q       <= 1'b0;
      failsafe_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      frame_cnt_q   <= frame_cnt_d;
      stale_q       <= stale_d;
      motor_q       <= (state_d == StRun) ? active_d : '0;
      armed_q       <= (state_d == StRun) || (state_d == StFailsafe);
      failsafe_q    <= (state_d == StFailsafe);
    end
  end

  assign motor_val_0 = motor_q[0*W +: W];
  assign motor_val_1 = motor_q[1*W +: W];
  assign motor_val_2 = motor_q[2*W +: W];
  assign motor_val_3 = motor_q[3*W +: W];
  assign armed       = armed_q;
  assign failsafe    = failsafe_q;

endmodule
